// File: rtl/uart_byte_fifo_pkg.sv
// Shared definitions for the UART loopback byte FIFO: byte width and output FSM encoding.
package uart_byte_fifo_pkg;

    localparam int unsigned UART_BYTE_W = 8;

    // Output-side handshake with rs232tx.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSend = 2'd1,
        StArm  = 2'd2,
        StWait = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_byte_fifo_ram.sv
// Byte storage for the FIFO: synchronous write, asynchronous read (maps to MLAB or registers).
module uart_byte_fifo_ram
    import uart_byte_fifo_pkg::*;
#(
    parameter int unsigned ADDR_W = 4
) (
    input  logic                   clock,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      waddr,
    input  logic [UART_BYTE_W-1:0] wdata,
    input  logic [ADDR_W-1:0]      raddr,
    output logic [UART_BYTE_W-1:0] rdata
);

    logic [UART_BYTE_W-1:0] mem [2**ADDR_W];

    // Write port: store the byte at the write address.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_byte_fifo.sv
// Elastic byte buffer between rs232rx and rs232tx. Adds OFFSET to every byte on the way out,
// only strobes the transmitter when it is idle, and counts bytes dropped on overflow.
module uart_byte_fifo
    import uart_byte_fifo_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter logic [7:0]  OFFSET     = 8'd1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [UART_BYTE_W-1:0] rx_q,
    input  logic                   rx_valid,
    output logic [UART_BYTE_W-1:0] tx_d,
    output logic                   tx_we,
    input  logic                   tx_busy,
    output logic [DEPTH_LOG2:0]    count,
    output logic                   overflow,
    output logic [7:0]             drop_count
);

    localparam int unsigned          DEPTH     = 2**DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]  DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]  CNT_ONE   = (DEPTH_LOG2 + 1)'(1);

    tx_state_e               state;
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic [UART_BYTE_W-1:0]  rd_data;
    logic                    full;
    logic                    pop;
    logic                    push;
    logic                    drop;

    // The pop happens at the edge that ends SEND, so a full FIFO can still take a byte then.
    assign full = (count == DEPTH_CNT);
    assign pop  = (state == StSend);
    assign push = rx_valid && (!full || pop);
    assign drop = rx_valid && !push;

    uart_byte_fifo_ram #(
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clock (clock),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (rx_q),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // Pointer, occupancy and drop bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end
        end
    end

    // Output FSM with registered strobe and data. Reset lands in WAIT because rs232tx keeps
    // running across our reset and may still be shifting out a byte.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= StWait;
            tx_we <= 1'b0;
            tx_d  <= '0;
        end else begin
            tx_we <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (count != '0) begin
                        state <= StSend;
                        tx_we <= 1'b1;
                        tx_d  <= rd_data + OFFSET;
                    end
                end
                StSend: state <= StArm;
                // rs232tx raises busy one cycle after we; ignore it here.
                StArm:  state <= StWait;
                StWait: begin
                    if (!tx_busy) begin
                        state <= StIdle;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_fifo.sv
// Directed bench for uart_byte_fifo with a simple rs232tx busy model.
module tb_uart_byte_fifo;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_q = 8'd0;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_d;
    logic       tx_we;
    logic       tx_busy;
    logic [4:0] count;
    logic       overflow;
    logic [7:0] drop_count;

    int passed = 0;
    int total  = 0;

    // Transmitter model: busy rises the cycle after tx_we and lasts busy_len cycles.
    logic       force_busy = 1'b0;
    int         busy_len   = 10;
    int         busy_cnt   = 0;
    logic [7:0] rec[$];
    int         viol       = 0;
    logic       prev_we    = 1'b0;
    int         peak       = 0;

    assign tx_busy = force_busy || (busy_cnt != 0);

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (tx_we) begin
            rec.push_back(tx_d);
            busy_cnt <= busy_len;
            if (prev_we || tx_busy) viol <= viol + 1;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
        prev_we <= tx_we;
        if (int'(count) > peak) peak <= int'(count);
    end

    uart_byte_fifo #(
        .DEPTH_LOG2 (4),
        .OFFSET     (8'd1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rx_q       (rx_q),
        .rx_valid   (rx_valid),
        .tx_d       (tx_d),
        .tx_we      (tx_we),
        .tx_busy    (tx_busy),
        .count      (count),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    task automatic do_reset();
        @(negedge clock);
        reset    = 1'b1;
        rx_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic write_bytes(input int n, input logic [7:0] first, input bit incr);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            rx_q     = incr ? 8'(int'(first) + i) : first;
            rx_valid = 1'b1;
        end
        @(negedge clock);
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        total++; if (tx_we !== 1'b0) $display("FAIL rst_tx_we: got %b want 0", tx_we); else passed++;
        total++; if (tx_d !== 8'h00) $display("FAIL rst_tx_d: got %h want 00", tx_d); else passed++;
        total++; if (count !== 5'd0) $display("FAIL rst_count: got %0d want 0", count); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL rst_overflow: got %b want 0", overflow);
        else passed++;
        total++; if (drop_count !== 8'd0) $display("FAIL rst_drop: got %0d want 0", drop_count);
        else passed++;
        reset = 1'b0;
    endtask

    task automatic test_single();
        busy_len = 10;
        repeat (3) @(negedge clock);
        rec.delete();
        rx_q     = 8'h41;
        rx_valid = 1'b1;
        @(negedge clock);   // cycle N+1
        rx_valid = 1'b0;
        total++; if (count !== 5'd1) $display("FAIL single_count_n1: got %0d want 1", count);
        else passed++;
        total++; if (tx_we !== 1'b0) $display("FAIL single_we_n1: got %b want 0", tx_we);
        else passed++;
        @(negedge clock);   // cycle N+2
        total++; if (tx_we !== 1'b1) $display("FAIL single_we_n2: got %b want 1", tx_we);
        else passed++;
        total++; if (tx_d !== 8'h42) $display("FAIL single_tx_d: got %h want 42", tx_d);
        else passed++;
        @(negedge clock);
        total++; if (tx_we !== 1'b0) $display("FAIL single_we_n3: got %b want 0", tx_we);
        else passed++;
        total++; if (count !== 5'd0) $display("FAIL single_count_n3: got %0d want 0", count);
        else passed++;
        repeat (15) @(negedge clock);
        total++; if (rec.size() != 1) $display("FAIL single_pulses: got %0d want 1", rec.size());
        else passed++;
    endtask

    task automatic test_back_to_back();
        int bad;
        busy_len = 20;
        peak     = 0;
        rec.delete();
        write_bytes(5, 8'h00, 1'b1);
        for (int k = 0; k < 300 && rec.size() < 5; k++) @(negedge clock);
        total++; if (rec.size() != 5) $display("FAIL burst_pulses: got %0d want 5", rec.size());
        else passed++;
        bad = 0;
        foreach (rec[i]) if (rec[i] !== 8'(i + 1)) bad++;
        total++; if (bad != 0) $display("FAIL burst_order: got %0d wrong bytes want 0", bad);
        else passed++;
        total++; if (peak != 4 && peak != 5) $display("FAIL burst_peak: got %0d want 4 or 5", peak);
        else passed++;
        total++; if (viol != 0) $display("FAIL burst_handshake: got %0d violations want 0", viol);
        else passed++;
    endtask

    task automatic test_overflow();
        int bad;
        force_busy = 1'b1;
        do_reset();
        rec.delete();
        write_bytes(20, 8'hFF, 1'b0);
        total++; if (count !== 5'd16) $display("FAIL ovf_count: got %0d want 16", count);
        else passed++;
        total++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow);
        else passed++;
        total++; if (drop_count !== 8'd4) $display("FAIL ovf_drop: got %0d want 4", drop_count);
        else passed++;
        total++; if (rec.size() != 0) $display("FAIL ovf_no_tx: got %0d want 0", rec.size());
        else passed++;
        busy_len   = 3;
        force_busy = 1'b0;
        for (int k = 0; k < 400 && rec.size() < 16; k++) @(negedge clock);
        repeat (10) @(negedge clock);
        total++; if (rec.size() != 16) $display("FAIL ovf_drain_n: got %0d want 16", rec.size());
        else passed++;
        bad = 0;
        foreach (rec[i]) if (rec[i] !== 8'h00) bad++;
        total++; if (bad != 0) $display("FAIL ovf_drain_data: got %0d wrong bytes want 0", bad);
        else passed++;
        total++; if (count !== 5'd0) $display("FAIL ovf_drain_count: got %0d want 0", count);
        else passed++;
    endtask

    task automatic test_full_push_pop();
        bit seen;
        force_busy = 1'b1;
        do_reset();
        write_bytes(16, 8'h20, 1'b1);
        total++; if (count !== 5'd16) $display("FAIL fpp_fill: got %0d want 16", count);
        else passed++;
        force_busy = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clock);
            if (tx_we === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            $display("FAIL fpp_send: got no tx_we want tx_we within 10 cycles");
        end else begin
            passed++;
            rx_q     = 8'hAA;
            rx_valid = 1'b1;
            total++; if (tx_d !== 8'h21) $display("FAIL fpp_tx_d: got %h want 21", tx_d);
            else passed++;
            @(negedge clock);
            rx_valid = 1'b0;
            total++; if (count !== 5'd16) $display("FAIL fpp_count: got %0d want 16", count);
            else passed++;
            total++; if (drop_count !== 8'd0) $display("FAIL fpp_drop: got %0d want 0", drop_count);
            else passed++;
        end
    endtask

    task automatic test_drop_saturate();
        force_busy = 1'b1;
        do_reset();
        write_bytes(316, 8'h55, 1'b0);
        total++; if (count !== 5'd16) $display("FAIL sat_count: got %0d want 16", count);
        else passed++;
        total++; if (drop_count !== 8'd255) $display("FAIL sat_drop: got %0d want 255", drop_count);
        else passed++;
        total++; if (overflow !== 1'b1) $display("FAIL sat_flag: got %b want 1", overflow);
        else passed++;
        write_bytes(10, 8'h55, 1'b0);
        total++; if (drop_count !== 8'd255) $display("FAIL sat_hold: got %0d want 255", drop_count);
        else passed++;
    endtask

    task automatic test_reset_mid();
        force_busy = 1'b1;
        do_reset();
        write_bytes(3, 8'h01, 1'b1);
        total++; if (count !== 5'd3) $display("FAIL rmid_pre: got %0d want 3", count); else passed++;
        do_reset();
        total++; if (count !== 5'd0) $display("FAIL rmid_count: got %0d want 0", count); else passed++;
        total++; if (tx_we !== 1'b0) $display("FAIL rmid_we: got %b want 0", tx_we); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL rmid_ovf: got %b want 0", overflow);
        else passed++;
        rec.delete();
        write_bytes(1, 8'h10, 1'b0);
        repeat (10) @(negedge clock);
        total++; if (rec.size() != 0) $display("FAIL rmid_hold: got %0d pulses want 0", rec.size());
        else passed++;
        total++; if (count !== 5'd1) $display("FAIL rmid_count1: got %0d want 1", count);
        else passed++;
        force_busy = 1'b0;
        for (int k = 0; k < 20 && rec.size() < 1; k++) @(negedge clock);
        total++;
        if (rec.size() != 1) $display("FAIL rmid_pulses: got %0d want 1", rec.size());
        else if (rec[0] !== 8'h11) $display("FAIL rmid_tx_d: got %h want 11", rec[0]);
        else passed++;
        total++; if (viol != 0) $display("FAIL final_handshake: got %0d violations want 0", viol);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_push_pop();
        test_drop_saturate();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
